mem_port_arbiter: RTL

Round-robin arbiter sharing one memory/bus port among four requesters (e.g. I-fetch, D-load, D-store, debug) in the MIPS core. Grants ownership with a one-hot grant and drives the 2-bit select of the team's 4:1 mux (`mux_4_1`). Ownership is held until the owner signals completion. Arbitration is fair round-robin, starting from the requester after the last owner.

---
 rtl/mem_port_arbiter_pkg.sv | 6 +
 rtl/arb_rr_pick.sv | 17 +
 rtl/mux_4_1.sv | 13 +
 rtl/mem_port_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared requester count, FSM state and requester index type
package mem_port_arbiter_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic {IDLE, OWN} state_t;
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: rotate-priority picker; req in, ptr = last owner, win = first set req after ptr, found = any req
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               ptr,
  output idx_t               win,
  output logic               found
);
  // scan farthest offset first so the nearest set bit after ptr wins
  always_comb begin
    win = ptr;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[ptr + idx_t'(i)]) win = ptr + idx_t'(i);
  end
  assign found = |req;
endmodule

// File: rtl/mux_4_1.sv
// mux_4_1: 4:1 bus mux; a..d data in, sel index, y selected bus out
module mux_4_1 #(
  parameter int bus_size = 32
) (
  input  logic [bus_size-1:0] a,
  input  logic [bus_size-1:0] b,
  input  logic [bus_size-1:0] c,
  input  logic [bus_size-1:0] d,
  input  logic [1:0]          sel,
  output logic [bus_size-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of one memory port among 4 requesters.
//   in : clk, rst_n (async low), req[3:0], done[3:0], a..d[bus_size], mem_ready
//   out: gnt[3:0] one-hot, select[1:0], bus_out (comb mux), bus_valid, timeout
//   ARB_TIMEOUT_EN: revoke a grant held HOLD_MAX cycles and pulse timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int bus_size = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  done,
  input  logic [bus_size-1:0] a,
  input  logic [bus_size-1:0] b,
  input  logic [bus_size-1:0] c,
  input  logic [bus_size-1:0] d,
  input  logic                mem_ready,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [1:0]          select,
  output logic [bus_size-1:0] bus_out,
  output logic                bus_valid,
  output logic                timeout
);
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be 2..255");
  end
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  idx_t sel_q, sel_d, ptr_q, ptr_d, win;
  logic valid_q, valid_d, found, grant, rel, own_done, own_drop, expire;
  arb_rr_pick u_pick (.req(req), .ptr(ptr_q), .win(win), .found(found));
  mux_4_1 #(bus_size) u_mux (.a(a), .b(b), .c(c), .d(d), .sel(sel_q), .y(bus_out));
  // sel_q is the owner index whenever state_q is OWN
  assign own_done = done[sel_q];
  assign own_drop = !req[sel_q];
  assign grant    = state_q == IDLE && found && mem_ready;
  assign rel      = state_q == OWN && (own_done || own_drop || expire);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] LIM = CW'(HOLD_MAX - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  // cnt_q counts completed owned cycles, so the HOLD_MAX-th owned edge sees LIM
  assign expire = state_q == OWN && cnt_q == LIM;
  always_comb begin
    cnt_d = grant ? '0 : (state_q == OWN && cnt_q != LIM) ? cnt_q + CW'(1) : cnt_q;
    to_d  = expire && !own_done && !own_drop;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  assign timeout = to_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  always_comb state_d = grant ? OWN : rel ? IDLE : state_q;
  always_comb begin
    gnt_d   = grant ? NUM_REQ'(1) << win : rel ? '0 : gnt_q;
    sel_d   = grant ? win : sel_q;
    valid_d = grant ? 1'b1 : rel ? 1'b0 : valid_q;
    ptr_d   = rel ? sel_q : ptr_q;
  end
  assign gnt       = gnt_q;
  assign select    = sel_q;
  assign bus_valid = valid_q;
endmodule
